hazard_stall_unit: RTL and testbench

- Generates the `stall` and flush controls consumed by the pipeline registers: PC, IF_ID and ID_EXE.
- Detects three conditions:
  - load-use hazards between the ID and EXE stages;
  - taken branches resolved in EXE;
  - data-memory wait states.
- Sequences multi-cycle stalls and flushes with a small FSM and down-counter.
- Keeps a saturating count of stalled cycles for performance monitoring.

---
 rtl/hazard_stall_unit.sv | 179 +++++++++++++++++
 tb/tb_hazard_stall_unit.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit
// Produces the stall/flush controls for the PC, IF_ID and ID_EXE pipeline
// registers. Detects load-use hazards (ID vs EXE), taken branches resolved
// in EXE and data-memory wait states, sequences multi-cycle stalls/flushes
// with a small FSM plus down-counter, and keeps a saturating count of
// stalled cycles.
//
// Ports:
//   clock, reset                 rising-edge clock, synchronous active-high reset
//   ID_UC_B_R_Signal_Read        ID instruction reads the register bank
//   ID_RS1, ID_RS2, ID_USES_RS2  ID source registers / RS2 in use
//   EXE_UC_MemPara_B_Reg         EXE instruction is a load
//   EXE_UC_B_R_Signal_Write      EXE instruction writes the register bank
//   EXE_RD                       EXE destination register
//   EXE_BRANCH_TAKEN             branch in EXE resolved taken
//   MEM_DADO_BUSY                data memory not ready, freeze pipeline
//   PC_stall, IF_ID_stall, IF_ID_flush, ID_EXE_stall, ID_EXE_flush
//                                combinational pipeline controls
//   HZ_STATE                     current FSM state
//   HZ_STALL_COUNT               saturating count of PC_stall cycles
module hazard_stall_unit #(
  parameter int REG_ADDR_W          = 5,
  parameter int LOAD_STALL_CYCLES   = 1,
  parameter int BRANCH_FLUSH_CYCLES = 2,
  parameter int CNT_W               = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ID_UC_B_R_Signal_Read,
  input  logic [REG_ADDR_W-1:0] ID_RS1,
  input  logic [REG_ADDR_W-1:0] ID_RS2,
  input  logic                  ID_USES_RS2,
  input  logic                  EXE_UC_MemPara_B_Reg,
  input  logic                  EXE_UC_B_R_Signal_Write,
  input  logic [REG_ADDR_W-1:0] EXE_RD,
  input  logic                  EXE_BRANCH_TAKEN,
  input  logic                  MEM_DADO_BUSY,
  output logic                  PC_stall,
  output logic                  IF_ID_stall,
  output logic                  IF_ID_flush,
  output logic                  ID_EXE_stall,
  output logic                  ID_EXE_flush,
  output logic [1:0]            HZ_STATE,
  output logic [15:0]           HZ_STALL_COUNT
);

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_LOAD_STALL   = 2'd1,
    ST_BRANCH_FLUSH = 2'd2,
    ST_MEM_WAIT     = 2'd3
  } hz_state_e;

  hz_state_e             state_r, state_nxt_s;
  hz_state_e             saved_r, saved_nxt_s;
  hz_state_e             eff_state_s;
  logic [CNT_W-1:0]      cnt_r, cnt_nxt_s;
  logic [15:0]           stall_cnt_r;
  logic                  hz_s;
  logic                  pc_stall_s, if_id_stall_s, if_id_flush_s;
  logic                  id_exe_stall_s, id_exe_flush_s;

  // Load-use hazard: a load in EXE writes a register the ID instruction reads.
  assign hz_s = EXE_UC_MemPara_B_Reg & EXE_UC_B_R_Signal_Write &
                (EXE_RD != {REG_ADDR_W{1'b0}}) & ID_UC_B_R_Signal_Read &
                ((ID_RS1 == EXE_RD) | (ID_USES_RS2 & (ID_RS2 == EXE_RD)));

  // Leaving a memory freeze resumes whatever sequence was interrupted.
  assign eff_state_s = (state_r == ST_MEM_WAIT) ? saved_r : state_r;

  // Next-state, counter and control-output decode in priority order.
  always_comb begin
    state_nxt_s    = state_r;
    saved_nxt_s    = saved_r;
    cnt_nxt_s      = cnt_r;
    pc_stall_s     = 1'b0;
    if_id_stall_s  = 1'b0;
    if_id_flush_s  = 1'b0;
    id_exe_stall_s = 1'b0;
    id_exe_flush_s = 1'b0;
    if (reset) begin
      state_nxt_s = ST_IDLE;
      saved_nxt_s = ST_IDLE;
      cnt_nxt_s   = {CNT_W{1'b0}};
    end else if (MEM_DADO_BUSY) begin
      pc_stall_s     = 1'b1;
      if_id_stall_s  = 1'b1;
      id_exe_stall_s = 1'b1;
      state_nxt_s    = ST_MEM_WAIT;
      if (state_r != ST_MEM_WAIT) begin
        saved_nxt_s = state_r;
      end else begin
        saved_nxt_s = saved_r;
      end
    end else if (EXE_BRANCH_TAKEN) begin
      if_id_flush_s  = 1'b1;
      id_exe_flush_s = 1'b1;
      if (BRANCH_FLUSH_CYCLES > 1) begin
        state_nxt_s = ST_BRANCH_FLUSH;
        cnt_nxt_s   = CNT_W'(BRANCH_FLUSH_CYCLES - 1);
      end else begin
        state_nxt_s = ST_IDLE;
      end
    end else begin
      case (eff_state_s)
        ST_BRANCH_FLUSH: begin
          if_id_flush_s  = 1'b1;
          id_exe_flush_s = 1'b1;
          if (cnt_r == CNT_W'(1)) begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = {CNT_W{1'b0}};
          end else begin
            state_nxt_s = ST_BRANCH_FLUSH;
            cnt_nxt_s   = cnt_r - CNT_W'(1);
          end
        end
        ST_LOAD_STALL: begin
          pc_stall_s     = 1'b1;
          if_id_stall_s  = 1'b1;
          id_exe_flush_s = 1'b1;
          if (cnt_r == CNT_W'(1)) begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = {CNT_W{1'b0}};
          end else begin
            state_nxt_s = ST_LOAD_STALL;
            cnt_nxt_s   = cnt_r - CNT_W'(1);
          end
        end
        ST_IDLE: begin
          if (hz_s) begin
            pc_stall_s     = 1'b1;
            if_id_stall_s  = 1'b1;
            id_exe_flush_s = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
              state_nxt_s = ST_LOAD_STALL;
              cnt_nxt_s   = CNT_W'(LOAD_STALL_CYCLES - 1);
            end else begin
              state_nxt_s = ST_IDLE;
            end
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        default: begin
          // saved state is never MEM_WAIT; recover to IDLE defensively
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // FSM, saved-state and sequencing-counter registers.
  always_ff @(posedge clock) begin
    state_r <= state_nxt_s;
    saved_r <= saved_nxt_s;
    cnt_r   <= cnt_nxt_s;
  end

  // Saturating count of cycles in which the PC was held.
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt_r <= 16'd0;
    end else if (pc_stall_s && (stall_cnt_r != 16'hFFFF)) begin
      stall_cnt_r <= stall_cnt_r + 16'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign PC_stall       = pc_stall_s;
  assign IF_ID_stall    = if_id_stall_s;
  assign IF_ID_flush    = if_id_flush_s;
  assign ID_EXE_stall   = id_exe_stall_s;
  assign ID_EXE_flush   = id_exe_flush_s;
  assign HZ_STATE       = state_r;
  assign HZ_STALL_COUNT = stall_cnt_r;

endmodule

// File: tb/tb_hazard_stall_unit.sv
module tb_hazard_stall_unit;

  logic       clock = 1'b0;
  logic       reset;
  logic       ID_UC_B_R_Signal_Read;
  logic [4:0] ID_RS1, ID_RS2;
  logic       ID_USES_RS2;
  logic       EXE_UC_MemPara_B_Reg;
  logic       EXE_UC_B_R_Signal_Write;
  logic [4:0] EXE_RD;
  logic       EXE_BRANCH_TAKEN;
  logic       MEM_DADO_BUSY;

  logic        pc1, ifs1, iff1, ids1, idf1;
  logic [1:0]  st1;
  logic [15:0] cnt1;
  logic        pc3, ifs3, iff3, ids3, idf3;
  logic [1:0]  st3;
  logic [15:0] cnt3;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  hazard_stall_unit #(.REG_ADDR_W(5), .LOAD_STALL_CYCLES(1), .BRANCH_FLUSH_CYCLES(2), .CNT_W(4)) dut1 (
    .clock(clock), .reset(reset),
    .ID_UC_B_R_Signal_Read(ID_UC_B_R_Signal_Read), .ID_RS1(ID_RS1), .ID_RS2(ID_RS2),
    .ID_USES_RS2(ID_USES_RS2), .EXE_UC_MemPara_B_Reg(EXE_UC_MemPara_B_Reg),
    .EXE_UC_B_R_Signal_Write(EXE_UC_B_R_Signal_Write), .EXE_RD(EXE_RD),
    .EXE_BRANCH_TAKEN(EXE_BRANCH_TAKEN), .MEM_DADO_BUSY(MEM_DADO_BUSY),
    .PC_stall(pc1), .IF_ID_stall(ifs1), .IF_ID_flush(iff1), .ID_EXE_stall(ids1),
    .ID_EXE_flush(idf1), .HZ_STATE(st1), .HZ_STALL_COUNT(cnt1));

  hazard_stall_unit #(.REG_ADDR_W(5), .LOAD_STALL_CYCLES(3), .BRANCH_FLUSH_CYCLES(2), .CNT_W(4)) dut3 (
    .clock(clock), .reset(reset),
    .ID_UC_B_R_Signal_Read(ID_UC_B_R_Signal_Read), .ID_RS1(ID_RS1), .ID_RS2(ID_RS2),
    .ID_USES_RS2(ID_USES_RS2), .EXE_UC_MemPara_B_Reg(EXE_UC_MemPara_B_Reg),
    .EXE_UC_B_R_Signal_Write(EXE_UC_B_R_Signal_Write), .EXE_RD(EXE_RD),
    .EXE_BRANCH_TAKEN(EXE_BRANCH_TAKEN), .MEM_DADO_BUSY(MEM_DADO_BUSY),
    .PC_stall(pc3), .IF_ID_stall(ifs3), .IF_ID_flush(iff3), .ID_EXE_stall(ids3),
    .ID_EXE_flush(idf3), .HZ_STATE(st3), .HZ_STALL_COUNT(cnt3));

  typedef struct {
    logic       busy, br, ld, wr;
    logic [4:0] rd;
    logic       rden;
    logic [4:0] rs1, rs2;
    logic       u2;
    logic [4:0] exp_ctl;   // {pc, if_stall, if_flush, idexe_stall, idexe_flush}
    logic [1:0] exp_st1, exp_st3;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mk(input logic busy, br, ld, wr, input logic [4:0] rd,
                              input logic rden, input logic [4:0] rs1, rs2, input logic u2,
                              input logic [4:0] ctl, input logic [1:0] s1, s3);
    vec_t v;
    v.busy = busy; v.br = br; v.ld = ld; v.wr = wr; v.rd = rd; v.rden = rden;
    v.rs1 = rs1; v.rs2 = rs2; v.u2 = u2; v.exp_ctl = ctl; v.exp_st1 = s1; v.exp_st3 = s3;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic busy, br, ld, wr, input logic [4:0] rd,
                       input logic rden, input logic [4:0] rs1, rs2, input logic u2);
    MEM_DADO_BUSY = busy; EXE_BRANCH_TAKEN = br; EXE_UC_MemPara_B_Reg = ld;
    EXE_UC_B_R_Signal_Write = wr; EXE_RD = rd; ID_UC_B_R_Signal_Read = rden;
    ID_RS1 = rs1; ID_RS2 = rs2; ID_USES_RS2 = u2;
  endtask

  task automatic quiet();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0);
  endtask

  // hz on RS1=5 with only the load fields, for sequences
  task automatic hz_in();
    drive(1'b0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b1, 5'd5, 5'd0, 1'b0);
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
  endtask

  function automatic logic [4:0] ctl1();
    return {pc1, ifs1, iff1, ids1, idf1};
  endfunction

  function automatic logic [4:0] ctl3();
    return {pc3, ifs3, iff3, ids3, idf3};
  endfunction

  logic [4:0] exp_pc3_seq [8];
  logic [4:0] exp_ctl3_seq[8];
  logic [1:0] exp_st3_seq [8];

  initial begin
    reset = 1'b1;
    quiet();

    // reset dominates every event
    drive(1'b1, 1'b1, 1'b1, 1'b1, 5'd5, 1'b1, 5'd5, 5'd5, 1'b1);
    next_cycle();
    @(negedge clock);
    chk("reset_ctl_dut1", ctl1(), 5'b00000);
    chk("reset_ctl_dut3", ctl3(), 5'b00000);
    quiet();
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk("reset_state", st1, 2'd0);
    chk("reset_count", cnt1, 16'd0);
    chk("reset_state3", st3, 2'd0);

    // single-cycle decode table, each vector from a freshly reset IDLE state
    vecs[0]  = mk(0,0,0,0,5'd0,0,5'd0,5'd0,0, 5'b00000, 2'd0, 2'd0);
    vecs[1]  = mk(0,0,1,1,5'd5,1,5'd5,5'd0,0, 5'b11001, 2'd0, 2'd1);
    vecs[2]  = mk(0,0,1,1,5'd0,1,5'd0,5'd0,0, 5'b00000, 2'd0, 2'd0);
    vecs[3]  = mk(0,0,1,1,5'd5,1,5'd3,5'd5,0, 5'b00000, 2'd0, 2'd0);
    vecs[4]  = mk(0,0,1,1,5'd5,1,5'd3,5'd5,1, 5'b11001, 2'd0, 2'd1);
    vecs[5]  = mk(0,0,0,1,5'd5,1,5'd5,5'd0,0, 5'b00000, 2'd0, 2'd0);
    vecs[6]  = mk(0,0,1,0,5'd5,1,5'd5,5'd0,0, 5'b00000, 2'd0, 2'd0);
    vecs[7]  = mk(0,0,1,1,5'd5,0,5'd5,5'd0,0, 5'b00000, 2'd0, 2'd0);
    vecs[8]  = mk(0,1,0,0,5'd0,0,5'd0,5'd0,0, 5'b00101, 2'd2, 2'd2);
    vecs[9]  = mk(0,1,1,1,5'd5,1,5'd5,5'd0,0, 5'b00101, 2'd2, 2'd2);
    vecs[10] = mk(1,1,1,1,5'd5,1,5'd5,5'd0,0, 5'b11010, 2'd3, 2'd3);
    vecs[11] = mk(1,0,0,0,5'd0,0,5'd0,5'd0,0, 5'b11010, 2'd3, 2'd3);

    for (int i = 0; i < 12; i++) begin
      do_reset();
      drive(vecs[i].busy, vecs[i].br, vecs[i].ld, vecs[i].wr, vecs[i].rd,
            vecs[i].rden, vecs[i].rs1, vecs[i].rs2, vecs[i].u2);
      @(negedge clock);
      chk($sformatf("vec%0d_ctl1", i), ctl1(), vecs[i].exp_ctl);
      chk($sformatf("vec%0d_ctl3", i), ctl3(), vecs[i].exp_ctl);
      next_cycle();
      quiet();
      @(negedge clock);
      chk($sformatf("vec%0d_st1", i), st1, vecs[i].exp_st1);
      chk($sformatf("vec%0d_st3", i), st3, vecs[i].exp_st3);
      chk($sformatf("vec%0d_cnt1", i), cnt1, {15'd0, vecs[i].exp_ctl[4]});
    end

    // LOAD_STALL_CYCLES=1: exactly one stall cycle, then quiet
    do_reset();
    hz_in();
    @(negedge clock);
    chk("ls1_stall", ctl1(), 5'b11001);
    next_cycle();
    quiet();
    @(negedge clock);
    chk("ls1_after", ctl1(), 5'b00000);
    chk("ls1_count", cnt1, 16'd1);

    // LOAD_STALL_CYCLES=3 via RS2: three stall cycles, states 0,1,1,0
    do_reset();
    drive(1'b0, 1'b0, 1'b1, 1'b1, 5'd7, 1'b1, 5'd2, 5'd7, 1'b1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      chk($sformatf("ls3_state_c%0d", c), st3, (c == 0 || c == 3) ? 2'd0 : 2'd1);
      chk($sformatf("ls3_ctl_c%0d", c), ctl3(), (c < 3) ? 5'b11001 : 5'b00000);
      next_cycle();
      quiet();
    end
    chk("ls3_count", cnt3, 16'd3);

    // taken branch: two flush cycles then idle, winning over a simultaneous hz
    do_reset();
    drive(1'b0, 1'b1, 1'b1, 1'b1, 5'd5, 1'b1, 5'd5, 5'd0, 1'b0);
    @(negedge clock);
    chk("br_c0", ctl1(), 5'b00101);
    next_cycle();
    hz_in();
    @(negedge clock);
    chk("br_c1", ctl1(), 5'b00101);
    chk("br_c1_state", st1, 2'd2);
    next_cycle();
    quiet();
    @(negedge clock);
    chk("br_c2", ctl1(), 5'b00000);
    chk("br_c2_state", st1, 2'd0);
    chk("br_count", cnt1, 16'd0);

    // memory busy for 4 cycles interrupting a 3-cycle load stall after cycle 1
    exp_ctl3_seq = '{5'b11001, 5'b11010, 5'b11010, 5'b11010, 5'b11010, 5'b11001, 5'b11001, 5'b00000};
    exp_st3_seq  = '{2'd0, 2'd1, 2'd3, 2'd3, 2'd3, 2'd3, 2'd1, 2'd0};
    do_reset();
    for (int c = 0; c < 8; c++) begin
      if (c == 0) hz_in();
      else if (c < 5) drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0);
      else quiet();
      @(negedge clock);
      chk($sformatf("busy_ctl_c%0d", c), ctl3(), exp_ctl3_seq[c]);
      chk($sformatf("busy_state_c%0d", c), st3, exp_st3_seq[c]);
      next_cycle();
    end
    chk("busy_count", cnt3, 16'd7);

    // reset in the middle of a load stall leaves nothing behind
    do_reset();
    hz_in();
    next_cycle();
    quiet();
    reset = 1'b1;
    @(negedge clock);
    chk("midrst_ctl", ctl3(), 5'b00000);
    next_cycle();
    reset = 1'b0;
    @(negedge clock);
    chk("midrst_after_ctl", ctl3(), 5'b00000);
    chk("midrst_state", st3, 2'd0);
    chk("midrst_count", cnt3, 16'd0);

    // saturation: 65540 consecutive hz cycles on dut1
    do_reset();
    hz_in();
    for (int c = 0; c < 65540; c++) next_cycle();
    @(negedge clock);
    chk("sat_count", cnt1, 16'hFFFF);
    chk("sat_still_stalling", pc1, 1'b1);
    next_cycle();
    quiet();
    @(negedge clock);
    chk("sat_hold", cnt1, 16'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
